// File: rtl/alu_pkg.sv
// Shared types and widths for the execute-stage ALU.
// alu_op_t matches the 3-bit final op code driven by the ALU control decoder.
package alu_pkg;

   localparam int W   = 8;
   localparam int SHW = 3;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_SRL  = 3'b010,
      ALU_SLL  = 3'b011,
      ALU_XOR  = 3'b100,
      ALU_XRED = 3'b101,
      ALU_AND  = 3'b110,
      ALU_RSVD = 3'b111
   } alu_op_t;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } alu_state_t;

endpackage

// File: rtl/alu_single.sv
// Combinational single-cycle ALU: all non-shift ops plus the shift-by-zero case.
// Pure logic, no latency, no flow control.
module alu_single #(
   parameter int W = alu_pkg::W
) (
   input  alu_pkg::alu_op_t i_op,
   input  logic [W-1:0]     i_a,
   input  logic [W-1:0]     i_b,
   output logic [W-1:0]     o_result,
   output logic             o_carry
);
   import alu_pkg::*;

   logic [W:0] w_sum;
   logic [W:0] w_dif;

   // SUB carry is the carry-out of a + ~b + 1, i.e. set when there is no borrow
   assign w_sum = {1'b0, i_a} + {1'b0, i_b};
   assign w_dif = {1'b0, i_a} + {1'b0, ~i_b} + {{W{1'b0}}, 1'b1};

   always_comb begin
      o_result = '0;
      o_carry  = 1'b0;
      case (i_op)
         ALU_ADD: begin
            o_result = w_sum[W-1:0];
            o_carry  = w_sum[W];
         end
         ALU_SUB: begin
            o_result = w_dif[W-1:0];
            o_carry  = w_dif[W];
         end
         ALU_SRL,
         ALU_SLL:  o_result = i_a;
         ALU_XOR:  o_result = i_a ^ i_b;
         ALU_XRED: o_result = {{(W-1){1'b0}}, ^i_a};
         ALU_AND:  o_result = i_a & i_b;
         default:  o_result = '0;
      endcase
   end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: registered result/zero/carry with a one-cycle done pulse.
// Latency 1 for non-shift ops, n+1 for shift by n; in_ready low while shifting.
module alu_exec #(
   parameter int W   = alu_pkg::W,
   parameter int SHW = alu_pkg::SHW
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             start,
   output logic             in_ready,
   input  alu_pkg::alu_op_t op,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic [W-1:0]     result,
   output logic             zero,
   output logic             carry,
   output logic             done
);
   import alu_pkg::*;

   alu_state_t       r_state;
   alu_state_t       w_state_nxt;
   logic [W-1:0]     r_acc;
   logic [SHW-1:0]   r_cnt;
   logic             r_dir_right;

   logic             w_accept;
   logic [SHW-1:0]   w_shamt;
   logic             w_is_shift;
   logic             w_shift_go;
   logic             w_last;
   logic [W-1:0]     w_acc_shf;
   logic [W-1:0]     w_single_res;
   logic             w_single_carry;

   alu_single #(.W(W)) u_single (
      .i_op     (op),
      .i_a      (a),
      .i_b      (b),
      .o_result (w_single_res),
      .o_carry  (w_single_carry)
   );

   assign w_accept   = start && in_ready;
   assign w_shamt    = b[SHW-1:0];
   assign w_is_shift = (op == ALU_SRL) || (op == ALU_SLL);
   assign w_shift_go = w_accept && w_is_shift && (w_shamt != '0);
   assign w_last     = (r_state == S_SHIFT) && (r_cnt == SHW'(1));
   assign w_acc_shf  = r_dir_right ? (r_acc >> 1) : (r_acc << 1);

   always_ff @(posedge Clk) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_shift_go) w_state_nxt = S_SHIFT;
         S_SHIFT: if (w_last)     w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (r_state == S_IDLE);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_dir_right <= 1'b0;
         result      <= '0;
         zero        <= 1'b0;
         carry       <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (w_accept && !w_shift_go) begin
            result <= w_single_res;
            zero   <= (w_single_res == '0);
            carry  <= w_single_carry;
            done   <= 1'b1;
         end
         if (w_shift_go) begin
            r_acc       <= a;
            r_cnt       <= w_shamt;
            r_dir_right <= (op == ALU_SRL);
         end
         // one bit position per cycle; the final step lands straight in result
         if (r_state == S_SHIFT) begin
            r_acc <= w_acc_shf;
            r_cnt <= r_cnt - SHW'(1);
            if (w_last) begin
               result <= w_acc_shf;
               zero   <= (w_acc_shf == '0);
               carry  <= 1'b0;
               done   <= 1'b1;
            end
         end
      end
   end

endmodule
